// File: rtl/mole_round_scheduler.sv
// Round sequencer for the whack-a-mole game: requests a pattern from the RNG,
// shows it for UP_TICKS, scores hits, then waits GAP_TICKS before the next round.
module mole_round_scheduler #(
    parameter int NUM_ROUNDS = 20,
    parameter int UP_TICKS   = 1000,
    parameter int GAP_TICKS  = 250,
    parameter int RNG_HOLD   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        tick,
    input  logic [17:0] hit,
    input  logic [17:0] rng_value,
    output logic        rng_change,
    output logic [17:0] leds,
    output logic [7:0]  score,
    output logic [7:0]  misses,
    output logic [7:0]  round_num,
    output logic        busy,
    output logic        game_over
);

    localparam int TMAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int HW   = $clog2(RNG_HOLD);

    localparam logic [TW-1:0] UP_LOAD    = TW'(UP_TICKS);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_TICKS);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RNG_HOLD - 1);
    localparam logic [7:0]    LAST_ROUND = 8'(NUM_ROUNDS);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_SHOW, S_GAP, S_DONE} state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [HW-1:0]   r_hold;
    logic [17:0]     r_leds;
    logic [7:0]      r_score;
    logic [7:0]      r_misses;
    logic [7:0]      r_round;
    logic            r_rng_change;
    logic            r_busy;
    logic            r_game_over;

    logic [17:0]     w_lit;
    logic [17:0]     w_stray;
    logic [17:0]     w_leds_after;
    logic            w_timer_done;
    logic            w_cleared;

    function automatic logic [4:0] popcount18(input logic [17:0] v);
        logic [4:0] c;
        c = '0;
        for (int k = 0; k < 18; k++) c = c + 5'(v[k]);
        return c;
    endfunction

    // Sum in 9 bits so the carry out tells us to clamp at 255.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [4:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {4'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign w_lit        = hit & r_leds;
    assign w_stray      = hit & ~r_leds;
    assign w_leds_after = r_leds & ~hit;
    assign w_timer_done = tick && (r_timer == TW'(1));
    assign w_cleared    = (|w_lit) && (w_leds_after == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_hold       <= '0;
            r_leds       <= '0;
            r_score      <= '0;
            r_misses     <= '0;
            r_round      <= '0;
            r_rng_change <= 1'b0;
            r_busy       <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_REQ;
                        r_score      <= '0;
                        r_misses     <= '0;
                        r_round      <= 8'd1;
                        r_rng_change <= 1'b1;
                        r_hold       <= '0;
                        r_busy       <= 1'b1;
                        r_game_over  <= 1'b0;
                    end
                end
                S_REQ: begin
                    // The generator output is only trusted on the last held cycle.
                    if (r_hold == HOLD_LAST) begin
                        r_rng_change <= 1'b0;
                        r_hold       <= '0;
                        r_leds       <= (rng_value == '0) ? 18'h00001 : rng_value;
                        r_timer      <= UP_LOAD;
                        r_state      <= S_SHOW;
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                S_SHOW: begin
                    r_score  <= sat_add(r_score, popcount18(w_lit));
                    r_misses <= sat_add(r_misses, popcount18(w_stray));
                    if (w_timer_done || w_cleared) begin
                        r_leds  <= '0;
                        r_timer <= GAP_LOAD;
                        r_state <= S_GAP;
                    end else begin
                        r_leds <= w_leds_after;
                        if (tick) r_timer <= r_timer - TW'(1);
                    end
                end
                S_GAP: begin
                    if (w_timer_done) begin
                        r_timer <= '0;
                        if (r_round == LAST_ROUND) begin
                            r_state     <= S_DONE;
                            r_busy      <= 1'b0;
                            r_game_over <= 1'b1;
                        end else begin
                            r_round      <= r_round + 8'd1;
                            r_state      <= S_REQ;
                            r_rng_change <= 1'b1;
                            r_hold       <= '0;
                        end
                    end else if (tick) begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rng_change = r_rng_change;
    assign leds       = r_leds;
    assign score      = r_score;
    assign misses     = r_misses;
    assign round_num  = r_round;
    assign busy       = r_busy;
    assign game_over  = r_game_over;

endmodule
